// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: multiply sequencer state encoding and default operand width.
package pipeline_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Step counter must reach WIDTH-1, with one spare bit of headroom.
    function automatic int unsigned mul_cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Iterative shift-add multiplier datapath: one multiplier bit per step, low WIDTH product bits.
module mul_shift_add_dp
    import pipeline_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc,
    output logic             last,
    output logic             mplier_zero
);

    localparam int unsigned CNT_W = mul_cnt_width(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == CNT_W'(WIDTH - 1));
    // Looks at the multiplier as it will be after this step's shift.
    assign mplier_zero = (mplier_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Execute-stage MUL sequencer: schedules the shift-add datapath and stalls the pipe until DONE.
module mul_sequencer
    import pipeline_pkg::*;
#(
    parameter int unsigned WIDTH      = MUL_WIDTH,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_valid_mul,
    input  logic [WIDTH-1:0] x_op_a,
    input  logic [WIDTH-1:0] x_op_b,
    input  logic             x_advance,
    input  logic             x_flush,
    output logic             x_alu_ready,
    output logic [WIDTH-1:0] mul_result,
    output logic             mul_busy
);

    mul_state_t state_q, state_d;

    logic dp_load;
    logic dp_step;
    logic dp_last;
    logic dp_mplier_zero;

    always_comb begin
        state_d = state_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        if (x_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (x_valid_mul) begin
                        dp_load = 1'b1;
                        // A zero multiplier needs no steps; acc is cleared by the load.
                        state_d = (EARLY_EXIT && (x_op_b == '0)) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    dp_step = 1'b1;
                    if (dp_last || (EARLY_EXIT && dp_mplier_zero)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (x_advance) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    mul_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clock      (clock),
        .reset      (reset),
        .load       (dp_load),
        .step       (dp_step),
        .op_a       (x_op_a),
        .op_b       (x_op_b),
        .acc        (mul_result),
        .last       (dp_last),
        .mplier_zero(dp_mplier_zero)
    );

    assign x_alu_ready = ~x_valid_mul | (state_q == DONE);
    assign mul_busy    = (state_q == BUSY);

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle integer multiply sequencer for the Execute stage. It owns an iterative shift-add multiplier and drives `x_alu_ready` for the hazard detection unit, so a MUL held in Execute stalls Decode and Fetch until its result is valid. It is the only scheduler of the multiplier datapath. It returns the low `WIDTH` bits of the product, which are identical for signed and unsigned operands.

## Interface
- `WIDTH`, 32: operand and result width.
- `EARLY_EXIT`, 1: when 1, the sequence ends as soon as the remaining multiplier bits are all zero.

Ports:
- `clock` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `x_valid_mul` in 1: Execute holds a MUL. Level signal, held high while the instruction stays in Execute.
- `x_op_a` in WIDTH: multiplicand (rs1 value after forwarding).
- `x_op_b` in WIDTH: multiplier (rs2 value after forwarding).
- `x_advance` in 1: the Execute→Memory register captures this cycle.
- `x_flush` in 1: kill the instruction in Execute.
- `x_alu_ready` out 1: to hazard detection; low means stall Execute.
- `mul_result` out WIDTH: product low bits; valid while in DONE.
- `mul_busy` out 1: state is BUSY.

## Operation
- States: IDLE, BUSY, DONE. Internal registers: `acc`, `mcand`, `mplier`, and a `cnt` of width clog2(WIDTH)+1.
- `x_alu_ready = ~x_valid_mul | (state == DONE)` (combinational). A non-MUL instruction is never stalled by this block.
- IDLE:
  - If `x_valid_mul & ~x_flush`: load `mcand=x_op_a`, `mplier=x_op_b`, `acc=0`, `cnt=0`, and go to BUSY.
  - Exception: if `EARLY_EXIT` and `x_op_b==0`, go straight to DONE with `acc=0`.
- BUSY, each cycle:
  - If `mplier[0]`, then `acc += mcand` (mod 2^WIDTH).
  - Then `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - Go to DONE when `cnt == WIDTH-1`, or when `EARLY_EXIT` and the shifted `mplier == 0`.
- DONE:
  - `mul_result = acc`.
  - Hold indefinitely while `x_advance` is low, for example while the memory stage stalls.
  - On `x_advance`, go to IDLE. A following MUL entering Execute in the next cycle starts normally from IDLE.
- `x_flush` in any state forces IDLE on the next edge and has priority over `x_advance` and `x_valid_mul`. In-flight work is discarded.
- Operands are sampled only on the IDLE→BUSY edge. Later changes on `x_op_a`/`x_op_b` (forwarding changes) are ignored until the next start.
- Reset: state IDLE; `acc`, `mcand`, `mplier`, `cnt` all 0. Resulting outputs: `mul_result=0`, `mul_busy=0`, `x_alu_ready` follows `~x_valid_mul`. Reset has the same effect mid-operation.

## Timing
- MUL present in Execute in cycle t, state IDLE: `x_alu_ready=0` from cycle t.
- Full latency (`EARLY_EXIT=0`, or a multiplier with its top bit set): BUSY for cycles t+1..t+WIDTH, DONE and `x_alu_ready=1` in cycle t+WIDTH+1. That is WIDTH+1 stall cycles.
- Early exit with k = index of the highest set bit of `x_op_b`: DONE in cycle t+k+2.
- Early exit with `x_op_b==0`: DONE in cycle t+1, one stall cycle.
- `mul_result` is registered and stable for every DONE cycle.
- Flush or reset at edge e: IDLE in the cycle after e. `x_alu_ready` depends only on `x_valid_mul` from then on.

## Structure
- Shared package `pipeline_pkg`:
  - state enum `mul_state_t` {IDLE, BUSY, DONE};
  - constant `MUL_WIDTH = 32`.
- One sub-module: `mul_shift_add_dp`, the datapath. It holds `acc`, `mcand`, `mplier` and `cnt`, with `load`/`step` controls and `last`/`mplier_zero` status outputs. The FSM and the ready logic stay in `mul_sequencer`.

## Test plan
- `EARLY_EXIT=0`, a=7, b=6 → `x_alu_ready` low for exactly 33 cycles; then `mul_result=42` with `x_alu_ready=1`.
- `EARLY_EXIT=1`, a=7, b=6 → DONE at t+4, result 42. a=5, b=0 → DONE at t+1, result 0.
- a=0xFFFFFFFF, b=0xFFFFFFFF → result 0x00000001 after 33 stall cycles. a=0x80000000, b=2 → result 0.
- Keep `x_advance` low for 3 cycles in DONE → result and ready held. Then `x_advance` with a second MUL (3×4) next cycle → restart from IDLE, result 12.
- `x_flush` at BUSY cycle 10, with `x_advance` also high → IDLE next cycle, `mul_busy=0`, no DONE reached.
- Assert `reset` mid-BUSY → next cycle IDLE, `mul_result=0`. With `x_valid_mul=0`, `x_alu_ready=1` in every cycle.
